// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one 32-bit ADD/SUB/AND/OR ALU between two requesters using
// round-robin arbitration. An accepted operation is registered (IDLE),
// evaluated (EXEC) and presented on a valid/ready response port (RESP).
// The block also holds the architectural NZCV flag register, written only
// by operations issued with the set-flags bit.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   reqN_valid / reqN_ready request handshake for requester N (0/1)
//   reqN_a, reqN_b          operands
//   reqN_ctrl               00 ADD, 01 SUB (a-b), 10 AND, 11 OR
//   reqN_s                  operation updates flags_q
//   rsp_valid / rsp_ready   response handshake
//   rsp_id                  requester that was served
//   rsp_result, rsp_flags   ALU result and its {N,Z,C,V}
//   flags_q                 architectural {N,Z,C,V} register
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_ctrl,
    input  logic             req0_s,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_ctrl,
    input  logic             req1_s,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [3:0]       flags_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             last_id_r;
    logic             sel_valid_s;
    logic             sel_id_s;
    logic             accept_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [1:0]       ctrl_r;
    logic             s_r;
    logic             id_r;
    logic [WIDTH+3:0] alu_out_s;

    // Returns {N,Z,C,V,result}. SUB is a + ~b + 1, so C=1 means no borrow.
    function automatic logic [WIDTH+3:0] alu_eval(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       ctrl
    );
        logic [WIDTH-1:0] b_eff;
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
        b_eff = (ctrl == 2'b01) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (ctrl == 2'b01)};
        case (ctrl)
            2'b00, 2'b01: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                // Overflow: operands share a sign the result does not.
                v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            2'b10: begin
                res = a & b;
                c   = 1'b0;
                v   = 1'b0;
            end
            2'b11: begin
                res = a | b;
                c   = 1'b0;
                v   = 1'b0;
            end
            default: begin
                res = {WIDTH{1'b0}};
                c   = 1'b0;
                v   = 1'b0;
            end
        endcase
        return {res[WIDTH-1], (res == {WIDTH{1'b0}}), c, v, res};
    endfunction

    // Round-robin selection; a tie goes to the requester not served last.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_id_s    = 1'b0;
        case ({req1_valid, req0_valid})
            2'b01: begin
                sel_valid_s = 1'b1;
                sel_id_s    = 1'b0;
            end
            2'b10: begin
                sel_valid_s = 1'b1;
                sel_id_s    = 1'b1;
            end
            2'b11: begin
                sel_valid_s = 1'b1;
                sel_id_s    = ~last_id_r;
            end
            default: begin
                sel_valid_s = 1'b0;
                sel_id_s    = 1'b0;
            end
        endcase
    end

    assign accept_s   = (state_r == IDLE) && sel_valid_s;
    assign req0_ready = accept_s && !sel_id_s;
    assign req1_ready = accept_s && sel_id_s;
    assign alu_out_s  = alu_eval(a_r, b_r, ctrl_r);

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC: begin
                state_next_s = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture on accept; last_id starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            ctrl_r    <= 2'b00;
            s_r       <= 1'b0;
            id_r      <= 1'b0;
            last_id_r <= 1'b1;
        end else if (accept_s) begin
            a_r       <= sel_id_s ? req1_a    : req0_a;
            b_r       <= sel_id_s ? req1_b    : req0_b;
            ctrl_r    <= sel_id_s ? req1_ctrl : req0_ctrl;
            s_r       <= sel_id_s ? req1_s    : req0_s;
            id_r      <= sel_id_s;
            last_id_r <= sel_id_s;
        end
    end

    // Response registers load at the EXEC edge and hold until the next EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= {WIDTH{1'b0}};
            rsp_flags  <= 4'b0000;
        end else if (state_r == EXEC) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= id_r;
            rsp_result <= alu_out_s[WIDTH-1:0];
            rsp_flags  <= alu_out_s[WIDTH+3:WIDTH];
        end else if ((state_r == RESP) && rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

    // Architectural flags, written only by set-flags operations.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if ((state_r == EXEC) && s_r) begin
            flags_q <= alu_out_s[WIDTH+3:WIDTH];
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_ctrl, req1_ctrl;
    logic        req0_s, req1_s;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags, flags_q;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic [3:0]  fl;
        logic [3:0]  fq;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .req0_s(req0_s),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .req1_s(req1_s),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .flags_q(flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every completed response handshake against the scoreboard.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d result=%h with nothing expected", rsp_id, rsp_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp", {23'd0, rsp_id, rsp_result, rsp_flags, flags_q},
                    {23'd0, e.id, e.res, e.fl, e.fq});
            end
        end
    end

    task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] c, input logic s);
        req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c; req0_s = s;
    endtask

    task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] c, input logic s);
        req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c; req1_s = s;
    endtask

    // Counts negedges until the given ready is seen (bounded).
    task automatic wait_ready(input logic id, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? req1_ready : req0_ready) && n < 20);
        if (!(id ? req1_ready : req0_ready)) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: req%0d_ready got 0 expected 1", id);
        end
    endtask

    task automatic push(input logic id, input logic [31:0] res, input logic [3:0] fl, input logic [3:0] fq);
        exp_t e;
        e.id = id; e.res = res; e.fl = fl; e.fq = fq;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int  n;
        logic [31:0] held;
        logic ok;
        reset = 1'b1;
        rsp_ready = 1'b1;
        set0(1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        set1(1'b0, 32'd0, 32'd0, 2'b00, 1'b0);

        // Reset values and IDLE selection with last_id=1.
        #2;
        chk("rst_state", {53'd0, rsp_valid, rsp_id, rsp_flags, flags_q}, 64'd0);
        chk("rst_result", {32'd0, rsp_result}, 64'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1 chk("rst_tie_ready", {62'd0, req1_ready, req0_ready}, 64'd1);
        req0_valid = 1'b0;
        #1 chk("rst_one_ready", {62'd0, req1_ready, req0_ready}, 64'd2);
        req1_valid = 1'b0;
        @(negedge clk) reset = 1'b0;

        // Single op: 0x7FFFFFFF + 1 with set-flags.
        @(posedge clk); #1;
        set0(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b1);
        wait_ready(1'b0, n);
        chk("single_accept", {32'd0, 31'd0, req1_ready, n}, {32'd0, 31'd0, 1'b0, 32'd1});
        push(1'b0, 32'h8000_0000, 4'b1001, 4'b1001);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk) chk("single_exec_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk) chk("single_resp_valid", {63'd0, rsp_valid}, 64'd1);
        drain();

        // Tie after reset.
        @(posedge clk); #1 reset = 1'b1; #1 reset = 1'b0;
        set0(1'b1, 32'd5, 32'd5, 2'b01, 1'b1);
        set1(1'b1, 32'h0000_00F0, 32'h0000_000F, 2'b11, 1'b0);
        wait_ready(1'b0, n);
        chk("tie_grant0", {62'd0, req1_ready, req0_ready}, 64'd1);
        push(1'b0, 32'd0, 4'b0110, 4'b0110);
        @(posedge clk); #1 req0_valid = 1'b0;
        wait_ready(1'b1, n);
        chk("tie_wait_cycles", 64'(n), 64'd3);
        push(1'b1, 32'h0000_00FF, 4'b0000, 4'b0110);
        @(posedge clk); #1 req1_valid = 1'b0;
        drain();

        // Backpressure: response held for 5 cycles, no requests accepted.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set0(1'b1, 32'h0F0F_0F0F, 32'hFFFF_0000, 2'b10, 1'b0);
        wait_ready(1'b0, n);
        push(1'b0, 32'h0F0F_0000, 4'b0000, 4'b0110);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        set1(1'b1, 32'd0, 32'd0, 2'b11, 1'b0);
        @(negedge clk);
        @(negedge clk);
        held = rsp_result;
        chk("bp_result", {32'd0, held}, {32'd0, 32'h0F0F_0000});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {29'd0, rsp_valid, req0_ready, req1_ready, rsp_result},
                {29'd0, 1'b1, 1'b0, 1'b0, held});
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk) chk("bp_idle_next", {62'd0, req1_ready, rsp_valid}, 64'd2);
        push(1'b1, 32'd0, 4'b0100, 4'b0110);
        @(posedge clk); #1 req1_valid = 1'b0;
        drain();

        // Fairness: both continuously valid for 6 operations.
        @(posedge clk); #1 reset = 1'b1; #1 reset = 1'b0;
        set0(1'b1, 32'd3, 32'd5, 2'b01, 1'b1);
        set1(1'b1, 32'h0000_00FF, 32'h0000_000F, 2'b10, 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic id;
            id = 1'(i % 2);
            wait_ready(id, n);
            chk("fair_spacing", 64'(n), (i == 0) ? 64'd1 : 64'd3);
            chk("fair_other", {63'd0, id ? req0_ready : req1_ready}, 64'd0);
            if (id) push(1'b1, 32'h0000_000F, 4'b0000, 4'b1000);
            else    push(1'b0, 32'hFFFF_FFFE, 4'b1000, 4'b1000);
            @(posedge clk);
        end
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Reset during EXEC drops the transaction and clears flags.
        @(posedge clk); #1;
        set1(1'b1, 32'hFFFF_FFFF, 32'd1, 2'b00, 1'b1);
        wait_ready(1'b1, n);
        @(posedge clk); #1 req1_valid = 1'b0;
        #2 reset = 1'b1;
        #1 chk("exec_rst_now", {59'd0, rsp_valid, flags_q}, 64'd0);
        reset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b0;
        end
        chk("exec_rst_no_rsp", {63'd0, ok}, 64'd1);

        // Next tie goes to requester 0; wrap-around add.
        @(posedge clk); #1;
        set0(1'b1, 32'hFFFF_FFFF, 32'd1, 2'b00, 1'b1);
        set1(1'b1, 32'd7, 32'd7, 2'b00, 1'b1);
        wait_ready(1'b0, n);
        chk("post_rst_tie", {62'd0, req1_ready, req0_ready}, 64'd1);
        push(1'b0, 32'd0, 4'b0110, 4'b0110);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
